// File: rtl/sfp_norm_sequencer.sv
// Purpose : lockstep sequencer for both cores' SFP/normalization pins; each row runs RD, ACC, XWR, XWAIT, XRD, DIV, WB.
// Latency : first RD one cycle after start; 6+SYNC_LAT cycles per row; done 1+N*(6+SYNC_LAT) cycles after start.
// Backpres: start is ignored while busy; with SEQ_STALL_EN, stall freezes the FSM and squashes the strobes.
//
// Optional feature macro: SEQ_STALL_EN (adds the 'stall' input).
//
// Ports:
//   clk                 sequencer clock; every output changes on its rising edge
//   reset               synchronous, active-low reset
//   start               one-cycle pass request; honoured only in IDLE
//   num_rows[4:0]       rows per pass (0..16), captured when start is accepted
//   stall               (SEQ_STALL_EN only) hold the current step and squash its strobes
//   sfp_inst[3:0]       [1:0] core1, [3:2] core2: 00 idle, 01 accumulate, 10 divide
//   norm_mem_addr[7:0]  [3:0] core1, [7:4] core2; both nibbles are always equal
//   norm_mem_rd[1:0]    per-core norm memory read enable, bit 0 = core1
//   norm_mem_wr[1:0]    per-core norm memory write enable
//   async_interface_wr  per-core partial-sum FIFO write
//   async_interface_rd  per-core partial-sum FIFO read
//   busy                high from start acceptance through the done cycle
//   done                one-cycle pulse at the end of a pass
module sfp_norm_sequencer #(
  parameter int SYNC_LAT  = 4,
  parameter int WB_OFFSET = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] num_rows,
`ifdef SEQ_STALL_EN
  input  logic       stall,
`endif
  output logic [3:0] sfp_inst,
  output logic [7:0] norm_mem_addr,
  output logic [1:0] norm_mem_rd,
  output logic [1:0] norm_mem_wr,
  output logic [1:0] async_interface_wr,
  output logic [1:0] async_interface_rd,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_ACC,
    S_XWR,
    S_XWAIT,
    S_XRD,
    S_DIV,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [1:0] SFP_NOP = 2'b00;
  localparam logic [1:0] SFP_ACC = 2'b01;
  localparam logic [1:0] SFP_DIV = 2'b10;

  // XWAIT is entered holding SYNC_LAT-1 and exits on zero, so it lasts
  // exactly SYNC_LAT cycles.
  localparam logic [3:0] WAIT_LOAD = 4'(SYNC_LAT - 1);
  // Truncating to 4 bits gives the modulo-16 write-back offset.
  localparam logic [3:0] WB_OFF    = 4'(WB_OFFSET);

  state_t     state;
  logic [4:0] row;       // 5 bits so a 16-row pass can compare against count-1 = 15
  logic [4:0] count;
  logic [3:0] wait_cnt;
  logic [3:0] addr_q;

  // One copy of each strobe; it is fanned out to both cores at the ports,
  // so the two cores can never see different values.
  logic [1:0] sfp_q;
  logic       rd_q;
  logic       wr_q;
  logic       awr_q;
  logic       ard_q;
  logic       done_q;

  // hold freezes all state; the registered strobes keep their values so the
  // interrupted step comes back by itself once stall drops.
  logic hold;
`ifdef SEQ_STALL_EN
  assign hold = stall && (state != S_IDLE);
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      row      <= 5'd0;
      count    <= 5'd0;
      wait_cnt <= 4'd0;
      addr_q   <= 4'd0;
      sfp_q    <= SFP_NOP;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      awr_q    <= 1'b0;
      ard_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (!hold) begin
      // Strobes are registered with the state they belong to. Each branch
      // sets the strobe of the state it moves into; all others default low.
      sfp_q  <= SFP_NOP;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      awr_q  <= 1'b0;
      ard_q  <= 1'b0;
      done_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            if (num_rows != 5'd0) begin
              count  <= num_rows;
              row    <= 5'd0;
              addr_q <= 4'd0;
              rd_q   <= 1'b1;
              state  <= S_RD;
            end else begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end

        S_RD: begin
          sfp_q <= SFP_ACC;
          state <= S_ACC;
        end

        S_ACC: begin
          awr_q <= 1'b1;
          state <= S_XWR;
        end

        S_XWR: begin
          wait_cnt <= WAIT_LOAD;
          state    <= S_XWAIT;
        end

        S_XWAIT: begin
          if (wait_cnt == 4'd0) begin
            ard_q <= 1'b1;
            state <= S_XRD;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_XRD: begin
          sfp_q <= SFP_DIV;
          state <= S_DIV;
        end

        S_DIV: begin
          wr_q   <= 1'b1;
          addr_q <= row[3:0] + WB_OFF;
          state  <= S_WB;
        end

        S_WB: begin
          if (row == count - 5'd1) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            row    <= row + 5'd1;
            addr_q <= row[3:0] + 4'd1;
            rd_q   <= 1'b1;
            state  <= S_RD;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign sfp_inst           = hold ? 4'd0 : {sfp_q, sfp_q};
  assign norm_mem_addr      = {addr_q, addr_q};
  assign norm_mem_rd        = {2{rd_q  & ~hold}};
  assign norm_mem_wr        = {2{wr_q  & ~hold}};
  assign async_interface_wr = {2{awr_q & ~hold}};
  assign async_interface_rd = {2{ard_q & ~hold}};
  assign done               = done_q & ~hold;
  assign busy               = (state != S_IDLE);

endmodule
